// File: rtl/dco_bank_cod.sv
// Slew-limited row/column thermometer coder for the DCO capacitor bank.
// Optional first-order dither on the applied code: define DCO_COD_DITHER_EN.
module dco_bank_cod #(
    parameter int ROW_W    = 4,
    parameter int COL_W    = 4,
    parameter int WORD_W   = ROW_W + COL_W,
    parameter int STEP_MAX = 4,
    parameter int RST_WORD = 1 << (WORD_W - 1),
    parameter int FRAC_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load,
    input  logic [WORD_W-1:0]          word,
`ifdef DCO_COD_DITHER_EN
    input  logic [FRAC_W-1:0]          frac,
`endif
    output logic [(1 << ROW_W)-1:0]    r_all,
    output logic [(1 << ROW_W)-1:0]    row,
    output logic [(1 << COL_W)-1:0]    col,
    output logic [WORD_W-1:0]          cur_word,
    output logic                       busy
);

    localparam int ROWS = 1 << ROW_W;
    localparam int COLS = 1 << COL_W;
    localparam logic [WORD_W-1:0] RST_C  = WORD_W'(RST_WORD);
    localparam logic [WORD_W:0]   STEP_L = (WORD_W + 1)'(STEP_MAX);

    if (WORD_W != ROW_W + COL_W || STEP_MAX < 1 || FRAC_W < 1) begin : g_param_chk
        $error("dco_bank_cod: inconsistent parameters");
    end

    typedef enum logic {
        IDLE,
        SLEW
    } state_e;

    function automatic logic [ROWS-1:0] dec_rall(input logic [WORD_W-1:0] a);
        logic [ROW_W-1:0] r;
        r = a[WORD_W-1:COL_W];
        for (int i = 0; i < ROWS; i++) begin
            dec_rall[i] = (i >= int'(r));
        end
    endfunction

    function automatic logic [ROWS-1:0] dec_row(input logic [WORD_W-1:0] a);
        logic [ROW_W-1:0] r;
        r = a[WORD_W-1:COL_W];
        for (int i = 0; i < ROWS; i++) begin
            dec_row[i] = (i == int'(r));
        end
    endfunction

    // Odd rows fill from the top column down so the partial row snakes.
    function automatic logic [COLS-1:0] dec_col(input logic [WORD_W-1:0] a);
        logic [COL_W-1:0] c;
        logic             odd;
        c   = a[COL_W-1:0];
        odd = a[COL_W];
        for (int j = 0; j < COLS; j++) begin
            dec_col[j] = odd ? (j >= COLS - int'(c)) : (j < int'(c));
        end
    endfunction

    state_e            state_q, state_d;
    logic [WORD_W-1:0] target_q, target_d;
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [ROWS-1:0]   r_all_q, r_all_d;
    logic [ROWS-1:0]   row_q, row_d;
    logic [COLS-1:0]   col_q, col_d;
    logic signed [WORD_W:0] diff;
    logic [WORD_W:0]   mag;
    logic [WORD_W:0]   step;
    logic [WORD_W-1:0] app;
`ifdef DCO_COD_DITHER_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic [WORD_W:0]   app_sum;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        r_all_d  = r_all_q;
        row_d    = row_q;
        col_d    = col_q;
        app      = cur_q;
        diff = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
        mag  = diff[WORD_W] ? (WORD_W + 1)'(-diff) : (WORD_W + 1)'(diff);
        step = (mag > STEP_L) ? STEP_L : mag;
`ifdef DCO_COD_DITHER_EN
        acc_d   = acc_q;
        acc_sum = '0;
        app_sum = '0;
`endif
        if (en) begin
            if (state_q == SLEW) begin
                if (diff[WORD_W]) begin
                    cur_d = cur_q - step[WORD_W-1:0];
                end else begin
                    cur_d = cur_q + step[WORD_W-1:0];
                end
                if (cur_d == target_q) begin
                    state_d = IDLE;
                end
            end
            if (load) begin
                target_d = word;
                state_d  = (word != cur_d) ? SLEW : IDLE;
            end
            app = cur_d;
`ifdef DCO_COD_DITHER_EN
            acc_sum = {1'b0, acc_q} + {1'b0, frac};
            acc_d   = acc_sum[FRAC_W-1:0];
            app_sum = {1'b0, cur_d} + {{WORD_W{1'b0}}, acc_sum[FRAC_W]};
            app     = app_sum[WORD_W] ? '1 : app_sum[WORD_W-1:0];
`endif
            r_all_d = dec_rall(app);
            row_d   = dec_row(app);
            col_d   = dec_col(app);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= RST_C;
            cur_q    <= RST_C;
            r_all_q  <= dec_rall(RST_C);
            row_q    <= dec_row(RST_C);
            col_q    <= dec_col(RST_C);
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            r_all_q  <= r_all_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

`ifdef DCO_COD_DITHER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign r_all    = r_all_q;
    assign row      = row_q;
    assign col      = col_q;
    assign cur_word = cur_q;
    assign busy     = (state_q == SLEW);

endmodule
